move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_move_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Move sequencer: queues tic-tac-toe move requests, validates each against the
// board, strobes the write, waits for the board acknowledge and reports a code.
module move_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_MAX   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_row,
  input  logic [1:0] req_col,
  output logic       set,
  output logic [1:0] row,
  output logic [1:0] col,
  input  logic [8:0] valid,
  input  logic [8:0] symbol,
  input  logic [1:0] game_state,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic [3:0] move_count,
  output logic       turn_x,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [1:0] CODE_OK      = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_OVER    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic [3:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      hold_row_q, hold_col_q;
  logic [1:0]      code_q;
  logic [TW-1:0]   wait_q;
  logic            next_turn_q;
  logic            set_q;
  logic [1:0]      row_q, col_q;
  logic            resp_valid_q;
  logic [1:0]      resp_code_q;
  logic [3:0]      move_count_q;
  logic            turn_x_q;

  logic            enq, deq;
  logic            legal;
  logic [3:0]      row_m1, col_m1, cell_idx;
  logic            cell_hit, cell_sym;

  always_comb begin
    req_ready = (count_q != CW'(FIFO_DEPTH));
    enq       = req_valid && req_ready;
    deq       = (state_q == IDLE) && (count_q != '0);
    count_d   = count_q + CW'(enq) - CW'(deq);
  end

  // The cell index is only meaningful for rows/columns 1..3; index 0 otherwise.
  always_comb begin
    legal    = (hold_row_q != 2'd0) && (hold_col_q != 2'd0);
    row_m1   = {2'b00, hold_row_q} - 4'd1;
    col_m1   = {2'b00, hold_col_q} - 4'd1;
    cell_idx = '0;
    if (legal) begin
      cell_idx = row_m1 * 4'd3 + col_m1;
    end
    cell_hit = legal && valid[cell_idx];
    cell_sym = symbol[cell_idx];
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_q[wr_ptr_q] <= {req_row, req_col};
    end
  end

  // Board-facing and response outputs are registered from the state they
  // belong to, so they appear in the cycle after ISSUE / RESP respectively.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_row_q   <= '0;
      hold_col_q   <= '0;
      code_q       <= CODE_OK;
      wait_q       <= '0;
      next_turn_q  <= 1'b0;
      set_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= CODE_OK;
      move_count_q <= '0;
      turn_x_q     <= 1'b1;
    end else begin
      count_q <= count_d;
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      set_q <= (state_q == ISSUE);
      if (state_q == ISSUE) begin
        row_q <= hold_row_q;
        col_q <= hold_col_q;
      end

      resp_valid_q <= (state_q == RESP);
      if (state_q == RESP) begin
        resp_code_q <= code_q;
        if (code_q == CODE_OK) begin
          if (move_count_q != 4'd9) begin
            move_count_q <= move_count_q + 4'd1;
          end
          turn_x_q <= next_turn_q;
        end
      end

      case (state_q)
        IDLE: begin
          if (deq) begin
            {hold_row_q, hold_col_q} <= fifo_q[rd_ptr_q];
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (game_state != 2'b00) begin
            code_q  <= CODE_OVER;
            state_q <= RESP;
          end else if (!legal || cell_hit) begin
            code_q  <= CODE_ILLEGAL;
            state_q <= RESP;
          end else begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Accepting the board's symbol keeps turn_x in step even when the
          // board wrote the unexpected player: next turn is its opposite.
          if (cell_hit) begin
            code_q      <= CODE_OK;
            next_turn_q <= ~cell_sym;
            state_q     <= RESP;
          end else if (wait_q == TW'(WAIT_MAX - 1)) begin
            code_q  <= CODE_TIMEOUT;
            state_q <= RESP;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    set        = set_q;
    row        = row_q;
    col        = col_q;
    resp_valid = resp_valid_q;
    resp_code  = resp_code_q;
    move_count = move_count_q;
    turn_x     = turn_x_q;
    busy       = (state_q != IDLE) || (count_q != '0);
  end

  a_set_single: assert property (@(posedge clk) disable iff (reset) set |=> !set);
  a_resp_single: assert property (@(posedge clk) disable iff (reset) resp_valid |=> !resp_valid);
  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: board model plus a game-level reference that
// predicts every response code, move count and turn from the game rules.
module tb_move_sequencer;

  localparam int DEPTH = 4;
  localparam int WMAX  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_row, req_col;
  logic       set;
  logic [1:0] row, col;
  logic [8:0] bvalid, bsym;
  logic [1:0] gs;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic [3:0] move_count;
  logic       turn_x;
  logic       busy;

  always #5 clk = ~clk;

  move_sequencer #(.FIFO_DEPTH(DEPTH), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .set(set), .row(row), .col(col),
    .valid(bvalid), .symbol(bsym), .game_state(gs), .resp_valid(resp_valid),
    .resp_code(resp_code), .move_count(move_count), .turn_x(turn_x), .busy(busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Game outcome from occupancy/symbol vectors: 0 on, 1 X won, 2 O won, 3 draw.
  function automatic logic [1:0] game_of(input logic [8:0] occ, input logic [8:0] sy);
    int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int i = 0; i < 8; i++) begin
      if (occ[ln[i][0]] && occ[ln[i][1]] && occ[ln[i][2]]) begin
        if (sy[ln[i][0]] && sy[ln[i][1]] && sy[ln[i][2]]) return 2'b01;
        if (!sy[ln[i][0]] && !sy[ln[i][1]] && !sy[ln[i][2]]) return 2'b10;
      end
    end
    if (&occ) return 2'b11;
    return 2'b00;
  endfunction

  always_comb gs = game_of(bvalid, bsym);

  // ---------------- board model ----------------
  bit          ack_en = 1'b1;
  int unsigned ack_delay_max = 0;
  int          flip_move = -1;
  bit          board_clr = 1'b0;
  bit          bx;
  int          wr_count;

  task automatic board_write(input int i);
    bit s;
    s = bx ^ (wr_count == flip_move);
    bvalid[i] <= 1'b1;
    bsym[i]   <= s;
    bx = ~s;
    wr_count++;
  endtask

  initial begin
    int pend_cnt, pend_idx, idx;
    int unsigned d;
    bit pend;
    bvalid <= '0; bsym <= '0; pend = 0; bx = 1; wr_count = 0;
    pend_cnt = 0; pend_idx = 0;
    forever begin
      @(posedge clk);
      if (board_clr) begin
        bvalid <= '0; bsym <= '0; pend = 0; bx = 1; wr_count = 0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            board_write(pend_idx);
            pend = 0;
          end else begin
            pend_cnt--;
          end
        end
        if (set && ack_en && row != 0 && col != 0) begin
          idx = (int'(row) - 1) * 3 + (int'(col) - 1);
          d = $urandom_range(0, ack_delay_max);
          if (d == 0) board_write(idx);
          else begin
            pend = 1; pend_cnt = int'(d) - 1; pend_idx = idx;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int got_q[$];
  int set_rows[$];
  int set_cnt = 0;
  int set_dbl = 0;

  initial begin
    bit set_prev;
    set_prev = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) got_q.push_back(int'(resp_code));
      if (set) begin
        set_cnt++;
        if (set_prev) set_dbl++;
        set_rows.push_back(int'(row) * 4 + int'(col));
      end
      set_prev = set;
    end
  end

  // ---------------- reference model ----------------
  logic [8:0] r_occ, r_sym;
  bit         r_x, r_turn;
  int         r_cnt, r_moves;
  int         exp_q[$];
  int         got_rd = 0;

  task automatic ref_clear();
    r_occ = '0; r_sym = '0; r_x = 1; r_turn = 1; r_cnt = 0; r_moves = 0;
    exp_q.delete();
  endtask

  task automatic predict(input int r, input int c, output int code);
    int i;
    bit s;
    if (game_of(r_occ, r_sym) != 2'b00) code = 2;
    else if (r == 0 || c == 0) code = 1;
    else begin
      i = (r - 1) * 3 + (c - 1);
      if (r_occ[i]) code = 1;
      else if (!ack_en) code = 3;
      else begin
        s = r_x ^ (r_moves == flip_move);
        r_occ[i] = 1'b1;
        r_sym[i] = s;
        r_x = ~s;
        r_turn = ~s;
        r_moves++;
        r_cnt = (r_cnt < 9) ? r_cnt + 1 : 9;
        code = 0;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input int r, input int c);
    int n, code;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_wait", int'(req_ready), 1);
    req_valid = 1'b1;
    req_row = 2'(r);
    req_col = 2'(c);
    predict(r, c, code);
    exp_q.push_back(code);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n, avail;
    n = 0;
    while (((got_q.size() - got_rd) < exp_q.size() || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    avail = got_q.size() - got_rd;
    chk({tag, "_nresp"}, avail, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < avail; k++) begin
      chk({tag, "_code"}, got_q[got_rd + k], exp_q[k]);
    end
    got_rd = got_q.size();
    exp_q.delete();
    chk({tag, "_count"}, int'(move_count), r_cnt);
    chk({tag, "_turn"}, int'(turn_x), int'(r_turn));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(req_ready), 1);
    chk({tag, "_set"}, int'(set), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_rvalid"}, int'(resp_valid), 0);
    chk({tag, "_rcode"}, int'(resp_code), 0);
    chk({tag, "_mcount"}, int'(move_count), 0);
    chk({tag, "_turnx"}, int'(turn_x), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; board_clr = 1'b1; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; board_clr = 1'b0;
    ref_clear();
    got_rd = got_q.size();
  endtask

  // Cycles (negedge samples) from the send returning until resp_valid is seen.
  task automatic latency(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 60);
    chk(tag, n, exp);
  endtask

  initial begin
    int mark, smark, nacc, ready6, gidx, nreq, r, c;
    int acc_list[$];
    int qr[6] = '{1, 1, 1, 2, 2, 2};
    int qc[6] = '{1, 2, 3, 1, 2, 3};

    reset = 1'b1; req_valid = 1'b0; req_row = '0; req_col = '0;
    do_reset();
    check_reset_outputs("rst0");

    // O wins; first move also measures the accepted-move latency.
    ack_en = 1; ack_delay_max = 0;
    send(1, 1);
    latency("lat_accept", 6);
    send(2, 2); send(1, 3); send(1, 2); send(3, 3); send(3, 2);
    drain("owin");
    chk("owin_gs", int'(gs), 2);
    smark = set_cnt;
    send(2, 1);
    drain("post");
    chk("post_noset", set_cnt, smark);

    // X wins.
    do_reset();
    send(1, 1); send(2, 2); send(1, 3); send(3, 2); send(1, 2);
    drain("xwin");
    chk("xwin_gs", int'(gs), 1);

    // Illegal moves.
    do_reset();
    send(1, 1);
    drain("ill_a");
    smark = set_cnt;
    send(1, 1);
    latency("lat_reject", 3);
    send(0, 2);
    drain("ill_b");
    chk("ill_noset", set_cnt, smark);

    // Board writes the unexpected symbol: move accepted, turn resynchronised.
    do_reset();
    flip_move = 0;
    send(2, 2);
    drain("resync");
    flip_move = -1;

    // Timeout after one accepted move.
    do_reset();
    send(1, 1);
    drain("to_pre");
    ack_en = 0;
    send(2, 2);
    latency("lat_timeout", 4 + WMAX);
    drain("timeout");
    ack_en = 1;

    // Queue limits with a stalled board.
    do_reset();
    ack_en = 0;
    smark = set_rows.size();
    nacc = 0; ready6 = -1;
    acc_list.delete();
    for (int i = 0; i < 6; i++) begin
      int code;
      req_valid = 1'b1;
      req_row = 2'(qr[i]);
      req_col = 2'(qc[i]);
      if (i == 5) ready6 = int'(req_ready);
      if (req_ready) begin
        nacc++;
        acc_list.push_back(qr[i] * 4 + qc[i]);
        predict(qr[i], qc[i], code);
        exp_q.push_back(code);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("q_accepted", nacc, 5);
    chk("q_ready_full", ready6, 0);
    drain("queue");
    chk("q_nsets", set_rows.size() - smark, acc_list.size());
    for (int k = 0; k < acc_list.size() && smark + k < set_rows.size(); k++) begin
      chk("q_order", set_rows[smark + k], acc_list[k]);
    end

    // Reset while waiting for the board, with a queued request and a
    // request offered during reset.
    send(3, 3);
    send(3, 1);
    mark = 0;
    while (!set && mark < 40) begin
      @(negedge clk);
      mark++;
    end
    chk("mid_set_seen", int'(set), 1);
    @(negedge clk);
    mark = got_q.size();
    smark = set_cnt;
    reset = 1'b1; board_clr = 1'b1;
    req_valid = 1'b1; req_row = 2'd1; req_col = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; board_clr = 1'b0;
    ref_clear();
    check_reset_outputs("rst_mid");
    repeat (20) @(negedge clk);
    chk("mid_noresp", got_q.size(), mark);
    chk("mid_noset", set_cnt, smark);
    chk("mid_idle", int'(busy), 0);
    got_rd = got_q.size();
    ack_en = 1;

    // Randomized games against the reference.
    ack_delay_max = WMAX - 2;
    for (gidx = 0; gidx < 8; gidx++) begin
      do_reset();
      nreq = int'($urandom_range(4, 14));
      for (int i = 0; i < nreq; i++) begin
        r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
        c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
        send(r, c);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain("rnd");
      chk("rnd_board", int'(bvalid), int'(r_occ));
      chk("rnd_gs", int'(gs), int'(game_of(r_occ, r_sym)));
    end

    chk("set_double", set_dbl, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
